// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports with write bypass,
// two write ports (port 1 wins), and a per-register busy scoreboard.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic [1:0]            wr_en,
  input  logic [2*AW-1:0]       wr_addr,
  input  logic [2*XLEN-1:0]     wr_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  output logic [CW-1:0]         busy_count,
  output logic                  wr_err
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_count_q, busy_count_d;
  logic             wr_err_q, wr_err_d;

  logic [AW-1:0]   wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;
  logic            wv0, wv1, iv;

  assign wa0 = wr_addr[0 +: AW];
  assign wa1 = wr_addr[AW +: AW];
  assign wd0 = wr_data[0 +: XLEN];
  assign wd1 = wr_data[XLEN +: XLEN];
  assign wv0 = wr_en[0] && (wa0 != '0);
  assign wv1 = wr_en[1] && (wa1 != '0);
  assign iv  = issue_en && (issue_addr != '0);

  // Writes clear busy before issue sets it, so a same-cycle issue keeps the bit.
  always_comb begin
    regs_d       = regs_q;
    busy_d       = busy_q;
    wr_err_d     = wr_err_q;
    busy_count_d = '0;
    if (wv0) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
      if (!busy_q[wa0] && !(iv && (issue_addr == wa0))) wr_err_d = 1'b1;
    end
    if (wv1) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
      if (!busy_q[wa1] && !(iv && (issue_addr == wa1))) wr_err_d = 1'b1;
    end
    if (iv) busy_d[issue_addr] = 1'b1;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
      wr_err_q     <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      wr_err_q     <= wr_err_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0, hit1;

    assign ra   = rd_addr[g*AW +: AW];
    assign hit0 = wv0 && (wa0 == ra);
    assign hit1 = wv1 && (wa1 == ra);

    always_comb begin
      if (ra == '0)  rd_data[g*XLEN +: XLEN] = '0;
      else if (hit1) rd_data[g*XLEN +: XLEN] = wd1;
      else if (hit0) rd_data[g*XLEN +: XLEN] = wd0;
      else           rd_data[g*XLEN +: XLEN] = regs_q[ra];
      rd_busy[g] = busy_q[ra] & ~(hit0 | hit1);
    end
  end

  assign busy_count = busy_count_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued when stimulus is
// driven and popped in order when the matching DUT output is sampled.
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_count;
  logic        wr_err;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy_count (busy_count),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required nothing queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    issue_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b1;
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    #1 reset_n = 1'b0;
    push("rst_rd0", 32'h0);
    push("rst_busy", 32'h0);
    push("rst_cnt", 32'h0);
    push("rst_err", 32'h0);
    #1;
    chk(rd_data[31:0]);
    chk(32'(rd_busy));
    chk(32'(busy_count));
    chk(32'(wr_err));
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // x0: issue and write are dropped
    issue_en = 1'b1; issue_addr = 5'd0;
    wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF_FFFF;
    rd_addr = {5'd0, 5'd0};
    push("x0_rd_same", 32'h0);
    push("x0_busy_same", 32'h0);
    #1;
    chk(rd_data[31:0]);
    chk(32'(rd_busy));
    push("x0_cnt", 32'h0);
    push("x0_err", 32'h0);
    push("x0_rd_after", 32'h0);
    step(); idle();
    #1;
    chk(32'(busy_count));
    chk(32'(wr_err));
    chk(rd_data[31:0]);

    // x7 scoreboard round trip
    push("x7_busy", 32'h1);
    push("x7_cnt", 32'h1);
    issue(5'd7);
    rd_addr = {5'd0, 5'd7};
    #1;
    chk(32'(rd_busy[0]));
    chk(32'(busy_count));
    wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'h0000_00AB;
    push("x7_busy_wr", 32'h0);
    push("x7_data_wr", 32'h0000_00AB);
    #1;
    chk(32'(rd_busy[0]));
    chk(rd_data[31:0]);
    push("x7_cnt_after", 32'h0);
    push("x7_err", 32'h0);
    step(); idle();
    #1;
    chk(32'(busy_count));
    chk(32'(wr_err));

    // x9 issue and write together keeps busy
    issue(5'd9);
    issue_en = 1'b1; issue_addr = 5'd9;
    wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h0000_0099;
    rd_addr = {5'd9, 5'd9};
    push("x9_busy_same", 32'h0);
    push("x9_data_same", 32'h0000_0099);
    #1;
    chk(32'(rd_busy[1]));
    chk(rd_data[63:32]);
    push("x9_busy_after", 32'h1);
    push("x9_data_after", 32'h0000_0099);
    push("x9_cnt", 32'h1);
    step(); idle();
    #1;
    chk(32'(rd_busy[1]));
    chk(rd_data[63:32]);
    chk(32'(busy_count));

    // x10 not busy, issued and written together: no error
    issue_en = 1'b1; issue_addr = 5'd10;
    wr_en = 2'b01; wr_addr[4:0] = 5'd10; wr_data[31:0] = 32'h0000_0010;
    push("x10_err", 32'h0);
    push("x10_cnt", 32'h2);
    step(); idle();
    #1;
    chk(32'(wr_err));
    chk(32'(busy_count));

    wr_en = 2'b11; wr_addr = {5'd9, 5'd10}; wr_data = {32'h9999_0000, 32'h1010_0000};
    push("clr_cnt", 32'h0);
    push("clr_err", 32'h0);
    step(); idle();
    #1;
    chk(32'(busy_count));
    chk(32'(wr_err));

    // bypass priority, both ports hitting x5
    issue(5'd5);
    issue(5'd6);
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h0000_2222, 32'h0000_1111};
    rd_addr = {5'd5, 5'd5};
    push("bp_same0", 32'h0000_2222);
    push("bp_same1", 32'h0000_2222);
    #1;
    chk(rd_data[31:0]);
    chk(rd_data[63:32]);
    push("bp_stored", 32'h0000_2222);
    step(); idle();
    #1;
    chk(rd_data[31:0]);
    wr_en = 2'b01; wr_addr[4:0] = 5'd6; wr_data[31:0] = 32'h0000_3333;
    rd_addr = {5'd6, 5'd6};
    push("bp0_same", 32'h0000_3333);
    #1;
    chk(rd_data[63:32]);
    push("bp0_stored", 32'h0000_3333);
    push("bp_err", 32'h0);
    push("bp_cnt", 32'h0);
    step(); idle();
    #1;
    chk(rd_data[63:32]);
    chk(32'(wr_err));
    chk(32'(busy_count));

    // write to non-busy x3 raises sticky error one edge later
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h0000_0033;
    push("err_same", 32'h0);
    #1;
    chk(32'(wr_err));
    push("err_next", 32'h1);
    step(); idle();
    #1;
    chk(32'(wr_err));

    // fill the scoreboard
    for (int i = 1; i < 32; i++) issue(5'(i));
    push("full_cnt", 32'd31);
    rd_addr = {5'd31, 5'd1};
    push("full_busy", 32'h3);
    #1;
    chk(32'(busy_count));
    chk(32'(rd_busy));
    rd_addr = {5'd0, 5'd0};
    push("full_busy_x0", 32'h0);
    #1;
    chk(32'(rd_busy));
    push("waw_cnt", 32'd31);
    issue(5'd1);
    #1;
    chk(32'(busy_count));

    // write every register, then reset asynchronously
    for (int i = 1; i < 32; i++) begin
      wr_en = 2'b01; wr_addr[4:0] = 5'(i); wr_data[31:0] = i * 32'h0101_0101;
      step();
    end
    idle();
    rd_addr = {5'd31, 5'd17};
    push("fill_cnt", 32'h0);
    push("fill_rd1", 32'h1F1F_1F1F);
    push("fill_rd0", 32'h1111_1111);
    #1;
    chk(32'(busy_count));
    chk(rd_data[63:32]);
    chk(rd_data[31:0]);
    issue_en = 1'b1; issue_addr = 5'd12;
    step(); idle();
    #2 reset_n = 1'b0;
    push("rst2_rd1", 32'h0);
    push("rst2_rd0", 32'h0);
    push("rst2_cnt", 32'h0);
    push("rst2_err", 32'h0);
    #1;
    chk(rd_data[63:32]);
    chk(rd_data[31:0]);
    chk(32'(busy_count));
    chk(32'(wr_err));
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      push("rst2_all_rd", 32'h0);
      push("rst2_all_busy", 32'h0);
      #1;
      chk(rd_data[31:0] | rd_data[63:32]);
      chk(32'(rd_busy));
    end
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
